rr_step_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one single-owner resource among `NREQ` requesters, such as a stepped state register or shared datapath port. It grants exactly one requester at a time and holds the grant until that requester signals `done`, drops its request, or exceeds a maximum tenure. After each release it rotates priority to the next index. It sits between the requesting blocks and the shared resource and drives that resource's owner select.

---
 rtl/rr_step_arbiter.sv | 111 +++++++++++
 tb/tb_rr_step_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/rr_step_arbiter.sv
// Round-robin owner select for one shared resource; grant 1 cycle after request, 2-cycle gap between owners.
// Tenure ends on owner req drop, done, or TIMEOUT (tmo pulse); `RR_ARB_LOCK_EN adds a lock input that freezes tenure.
module rr_step_arbiter #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 15
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic [NREQ-1:0]         req,
   input  logic                    done,
`ifdef RR_ARB_LOCK_EN
   input  logic                    lock,
`endif
   output logic [NREQ-1:0]         gnt,
   output logic [$clog2(NREQ)-1:0] gnt_id,
   output logic                    busy,
   output logic                    tmo
);

   localparam int IW = $clog2(NREQ);

   typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic [IW-1:0]   gnt_id_q, gnt_id_d;
   logic [7:0]      cnt_q, cnt_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic            tmo_q, tmo_d;
   logic [IW-1:0]   win;
   logic            rel;
   logic            lock_en;

`ifdef RR_ARB_LOCK_EN
   assign lock_en = lock;
`else
   assign lock_en = 1'b0;
`endif

   // Scan downward so the requester closest to ptr is the last to overwrite win.
   always_comb begin
      win = ptr_q;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req[ptr_q + IW'(k)]) win = ptr_q + IW'(k);
      end
   end

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      cnt_d    = cnt_q;
      gnt_d    = gnt_q;
      gnt_id_d = gnt_id_q;
      tmo_d    = 1'b0;
      rel      = 1'b0;
      case (state_q)
         IDLE: begin
            if (|req) begin
               gnt_d      = '0;
               gnt_d[win] = 1'b1;
               gnt_id_d   = win;
               cnt_d      = 8'd1;
               state_d    = GRANT;
            end
         end
         GRANT: begin
            if (!req[gnt_id_q]) begin
               rel = 1'b1;
            end else if (done && !lock_en) begin
               rel = 1'b1;
            end else if ((cnt_q == 8'(TIMEOUT)) && !lock_en) begin
               rel   = 1'b1;
               tmo_d = 1'b1;
            end else if (!lock_en) begin
               cnt_d = cnt_q + 8'd1;
            end
            if (rel) begin
               gnt_d   = '0;
               ptr_d   = gnt_id_q + IW'(1);
               state_d = RELEASE;
            end
         end
         RELEASE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         cnt_q    <= '0;
         gnt_q    <= '0;
         gnt_id_q <= '0;
         tmo_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         cnt_q    <= cnt_d;
         gnt_q    <= gnt_d;
         gnt_id_q <= gnt_id_d;
         tmo_q    <= tmo_d;
      end
   end

   assign gnt    = gnt_q;
   assign gnt_id = gnt_id_q;
   assign busy   = |gnt_q;
   assign tmo    = tmo_q;

endmodule

// File: tb/tb_rr_step_arbiter.sv
// Bench for rr_step_arbiter: directed scenarios then random traffic, every cycle compared with an owner/tenure model.
module tb_rr_step_arbiter;
   localparam int N  = 4;
   localparam int TO = 15;

   logic         clk  = 1'b0;
   logic         rstn = 1'b0;
   logic         done = 1'b0;
   logic         lock = 1'b0;
   logic [N-1:0] req  = '0;
   logic [N-1:0] gnt;
   logic [1:0]   gnt_id;
   logic         busy;
   logic         tmo;

   int checks   = 0;
   int failures = 0;

   // Model: who owns the resource, for how long, whose turn is next, turnaround cycles left.
   int m_owner = -1;
   int m_ptr   = 0;
   int m_last  = 0;
   int m_ten   = 0;
   int m_gap   = 0;
   bit m_tmo   = 1'b0;

   always #5 clk = ~clk;

   rr_step_arbiter #(.NREQ(N), .TIMEOUT(TO)) dut (
      .clk    (clk),
      .rstn   (rstn),
      .req    (req),
      .done   (done),
`ifdef RR_ARB_LOCK_EN
      .lock   (lock),
`endif
      .gnt    (gnt),
      .gnt_id (gnt_id),
      .busy   (busy),
      .tmo    (tmo)
   );

   function automatic void model_update();
      bit release_now;
      release_now = 1'b0;
      m_tmo = 1'b0;
      if (!rstn) begin
         m_owner = -1; m_ptr = 0; m_last = 0; m_ten = 0; m_gap = 0;
      end else if (m_owner >= 0) begin
         if (!req[m_owner]) release_now = 1'b1;
         else if (done && !lock) release_now = 1'b1;
         else if (m_ten == TO && !lock) begin release_now = 1'b1; m_tmo = 1'b1; end
         else if (!lock) m_ten++;
         if (release_now) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_gap   = 1;
         end
      end else if (m_gap > 0) begin
         m_gap--;
      end else if (req != '0) begin
         for (int k = 0; k < N; k++) begin
            if (m_owner < 0 && req[(m_ptr + k) % N]) begin
               m_owner = (m_ptr + k) % N;
               m_last  = m_owner;
               m_ten   = 1;
            end
         end
      end
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      logic [N-1:0] e;
      @(posedge clk);
      model_update();
      #1;
      e = '0;
      if (m_owner >= 0) e[m_owner] = 1'b1;
      chk("gnt", 32'(gnt), 32'(e));
      chk("gnt_id", 32'(gnt_id), 32'(m_last));
      chk("busy", 32'(busy), 32'(m_owner >= 0));
      chk("tmo", 32'(tmo), 32'(m_tmo));
   endtask

   task automatic wait_for(input logic val, input int max, output int n);
      n = 0;
      while (busy !== val && n < max) begin
         step();
         n++;
      end
      chk("wait_busy", 32'(busy), 32'(val));
   endtask

   initial begin
      int n;
      int cnt;

      // reset state
      rstn = 1'b0;
      step();
      step();
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);

      // reset in the middle of a grant
      rstn = 1'b1;
      req  = 4'b0100;
      step();
      chk("first_gnt", 32'(gnt), 32'h4);
      step();
      step();
      rstn = 1'b0;
      step();
      chk("mid_rst_gnt", 32'(gnt), 32'd0);
      chk("mid_rst_id", 32'(gnt_id), 32'd0);
      chk("mid_rst_tmo", 32'(tmo), 32'd0);
      rstn = 1'b1;
      step();
      chk("post_rst_gnt", 32'(gnt), 32'h4);

      // rotation with all requesters active, done in the third cycle of each tenure
      rstn = 1'b0;
      req  = '0;
      step();
      rstn = 1'b1;
      req  = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         wait_for(1'b1, 10, n);
         chk("rot_owner", 32'(gnt_id), 32'(k % N));
         if (k > 0) chk("rot_gap", 32'(n), 32'd2);
         step();
         step();
         done = 1'b1;
         step();
         done = 1'b0;
         chk("rot_rel", 32'(busy), 32'd0);
      end

      // pointer wrap and skip
      req = 4'b0100;
      wait_for(1'b1, 10, n);
      chk("ptr_owner2", 32'(gnt_id), 32'd2);
      done = 1'b1;
      step();
      done = 1'b0;
      req  = 4'b0011;
      wait_for(1'b1, 10, n);
      chk("wrap_gnt", 32'(gnt), 32'h1);
      done = 1'b1;
      step();
      done = 1'b0;
      wait_for(1'b1, 10, n);
      chk("skip_gnt", 32'(gnt), 32'h2);
      done = 1'b1;
      step();
      done = 1'b0;

      // timeout
      rstn = 1'b0;
      req  = '0;
      step();
      rstn = 1'b1;
      req  = 4'b0010;
      wait_for(1'b1, 10, n);
      cnt = 1;
      while (busy === 1'b1 && cnt < 40) begin
         step();
         if (busy === 1'b1) cnt++;
      end
      chk("to_tenure", 32'(cnt), 32'd15);
      chk("to_tmo", 32'(tmo), 32'd1);
      step();
      chk("to_tmo_pulse", 32'(tmo), 32'd0);
      step();
      chk("to_regrant", 32'(gnt), 32'h2);

      // done in the timeout cycle wins, then a one-cycle tenure
      for (int i = 1; i < TO; i++) step();
      done = 1'b1;
      step();
      done = 1'b0;
      chk("sim_busy", 32'(busy), 32'd0);
      chk("sim_tmo", 32'(tmo), 32'd0);
      step();
      step();
      chk("sim_regrant", 32'(gnt), 32'h2);
      req = '0;
      step();
      chk("one_cycle", 32'(busy), 32'd0);

`ifdef RR_ARB_LOCK_EN
      // lock freezes tenure and masks done
      rstn = 1'b0;
      step();
      rstn = 1'b1;
      req  = 4'b0001;
      wait_for(1'b1, 10, n);
      step();
      lock = 1'b1;
      for (int i = 2; i < 32; i++) begin
         done = (i == 10);
         step();
         chk("lock_hold", 32'(busy), 32'd1);
      end
      done = 1'b0;
      lock = 1'b0;
      cnt  = 0;
      while (busy === 1'b1 && cnt < 40) begin
         step();
         cnt++;
      end
      chk("lock_resume", 32'(cnt), 32'd14);
      chk("lock_tmo", 32'(tmo), 32'd1);
`endif

      // random traffic
      rstn = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 7) == 0) req = N'($urandom);
         done = ($urandom_range(0, 9) == 0);
         rstn = ($urandom_range(0, 199) != 0);
`ifdef RR_ARB_LOCK_EN
         if ($urandom_range(0, 9) == 0) lock = ~lock;
`endif
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
